// File: rtl/alb_seq.sv
// alb_seq: multi-precision sequencer that runs a WIDTH-bit operation through a 4-bit ALB, one nibble at a time
//
// Ports:
//   clk, reset_n             clock (rising edge), asynchronous active-low reset
//   start                    request, accepted only while busy=0
//   op, a_in, b_in, ci       operation, operands and nibble-0 carry-in, sampled at accept
//   abort                    (only with ALB_SEQ_ABORT_EN) cancel the running operation, no done
//   busy, done               operation in progress / one-cycle completion pulse
//   result, co, vo, no, zo   last completed result and flags, held until the next completion
//   alb_r, alb_s, alb_ci,
//   alb_i                    operand nibbles, carry-in and op select driven to the ALB
//   alb_f, alb_co, alb_vo    registered result nibble and flags returned by the ALB
//
// Optional feature: define ALB_SEQ_ABORT_EN to add the abort input.
module alb_seq #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
`ifdef ALB_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [1:0]       op,
    input  logic [4*NIB-1:0] a_in,
    input  logic [4*NIB-1:0] b_in,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [4*NIB-1:0] result,
    output logic             co,
    output logic             vo,
    output logic             no,
    output logic             zo,
    output logic [3:0]       alb_r,
    output logic [3:0]       alb_s,
    output logic             alb_ci,
    output logic [1:0]       alb_i,
    input  logic [3:0]       alb_f,
    input  logic             alb_co,
    input  logic             alb_vo
);
    localparam int W  = 4 * NIB;
    localparam int KW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    buf_q;
    logic [W-1:0]    buf_nxt;
    logic [1:0]      op_q;
    logic            carry;
    logic [KW-1:0]   k;
    logic            last;
    logic            issue;
    logic            abort_i;

`ifdef ALB_SEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Buffer as it will look once the nibble returned this cycle is written;
    // the final result is taken from here so it includes the last nibble.
    always_comb begin
        buf_nxt            = buf_q;
        buf_nxt[4*k +: 4]  = alb_f;
    end

    assign last   = (k == KW'(NIB - 1));
    assign issue  = (state == ISSUE);
    assign alb_r  = issue ? a_q[4*k +: 4] : 4'd0;
    assign alb_s  = issue ? b_q[4*k +: 4] : 4'd0;
    assign alb_ci = issue ? carry : 1'b0;
    assign alb_i  = issue ? op_q : 2'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            buf_q  <= '0;
            op_q   <= '0;
            carry  <= 1'b0;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            co     <= 1'b0;
            vo     <= 1'b0;
            no     <= 1'b0;
            zo     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        op_q  <= op;
                        carry <= ci;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= abort_i ? IDLE : CAPTURE;
                    busy  <= !abort_i;
                end
                CAPTURE: begin
                    // abort wins over a completing capture: nothing is published
                    if (abort_i) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        buf_q <= buf_nxt;
                        carry <= alb_co;
                        if (!last) begin
                            k     <= k + 1'b1;
                            state <= ISSUE;
                        end else begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            result <= buf_nxt;
                            co     <= alb_co;
                            vo     <= alb_vo;
                            no     <= buf_nxt[W-1];
                            zo     <= (buf_nxt == '0);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alb_seq.sv
// tb_alb_seq: self-checking bench for alb_seq with a registered 4-bit ALB model and a full-width reference
module tb_alb_seq;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         ci = 1'b0;
    logic         busy, done, co, vo, no, zo, alb_ci;
    logic [W-1:0] result;
    logic [3:0]   alb_r, alb_s;
    logic [1:0]   alb_i;
    logic [3:0]   alb_f = 4'd0;
    logic         alb_co = 1'b0;
    logic         alb_vo = 1'b0;
`ifdef ALB_SEQ_ABORT_EN
    logic         abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    alb_seq #(.NIB(NIB)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
`ifdef ALB_SEQ_ABORT_EN
        .abort(abort),
`endif
        .op(op), .a_in(a_in), .b_in(b_in), .ci(ci),
        .busy(busy), .done(done), .result(result),
        .co(co), .vo(vo), .no(no), .zo(zo),
        .alb_r(alb_r), .alb_s(alb_s), .alb_ci(alb_ci), .alb_i(alb_i),
        .alb_f(alb_f), .alb_co(alb_co), .alb_vo(alb_vo)
    );

    // 4-bit ALB: registers its inputs, result valid the cycle after issue
    function automatic logic [5:0] alb_model(logic [1:0] i, logic [3:0] r, logic [3:0] s, logic c);
        logic [4:0] t;
        logic [3:0] s2;
        s2 = (i == 2'b11) ? ~s : s;
        t  = {1'b0, r} + {1'b0, s2} + {4'd0, c};
        case (i)
            2'b00:   return {2'b00, r | s};
            2'b10:   return {2'b00, ~r & s};
            default: return {t[4], (r[3] == s2[3]) && (t[3] != r[3]), t[3:0]};
        endcase
    endfunction

    always @(posedge clk) {alb_co, alb_vo, alb_f} <= alb_model(alb_i, alb_r, alb_s, alb_ci);

    always @(negedge clk) if (done) done_cnt++;

    // whole-word reference: {result, co, vo, no, zo}
    function automatic logic [W+3:0] ref_op(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b, logic c);
        logic [W:0]   t;
        logic [W-1:0] bb;
        logic         v;
        bb = (o == 2'b11) ? ~b : b;
        case (o)
            2'b00:   t = {1'b0, a | b};
            2'b10:   t = {1'b0, ~a & b};
            default: t = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        endcase
        v = o[0] && (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
        return {t[W-1:0], t[W], v, t[W-1], t[W-1:0] == '0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start an operation now (we are just after an edge) and wait for done; lat = edges after accept
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input bit scramble, output int lat);
        op = o; a_in = a; b_in = b; ci = c; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (scramble) begin
                a_in = W'($urandom); b_in = W'($urandom); op = 2'($urandom); ci = 1'($urandom);
            end
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, co, vo, no, zo} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {busy, done, result, co, vo, no, zo});
        end
        checks++;
        if ({alb_r, alb_s, alb_ci, alb_i} !== '0) begin
            errors++;
            $display("FAIL reset_alb got %h want 0", {alb_r, alb_s, alb_ci, alb_i});
        end
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [1:0]   ops [6] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b10};
        logic [W-1:0] as  [6] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0001, 16'h0F0F, 16'h00FF};
        logic [W-1:0] bs  [6] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0002, 16'hF000, 16'h0F0F};
        logic         cs  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W+3:0] ex  [6] = '{{16'h2233, 4'b0000}, {16'h0000, 4'b1001}, {16'h7FFF, 4'b1100},
                                  {16'hFFFF, 4'b0010}, {16'hFF0F, 4'b0010}, {16'h0F00, 4'b0000}};
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], cs[i], 1'b0, lat);
            checks++;
            if (lat != 2 * NIB) begin
                errors++;
                $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, 2 * NIB);
            end
            checks++;
            if ({result, co, vo, no, zo} !== ex[i] || busy !== 1'b0) begin
                errors++;
                $display("FAIL directed_result[%0d] got %h busy=%b want %h busy=0", i, {result, co, vo, no, zo}, busy, ex[i]);
            end
            tick();
            checks++;
            if (done !== 1'b0 || {alb_r, alb_s, alb_ci, alb_i} !== '0 || {result, co, vo, no, zo} !== ex[i]) begin
                errors++;
                $display("FAIL directed_hold[%0d] done=%b alb=%h res=%h want done=0 alb=0 res=%h",
                         i, done, {alb_r, alb_s, alb_ci, alb_i}, {result, co, vo, no, zo}, ex[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]   o;
        logic [W-1:0] a, b;
        logic         c;
        logic [W+3:0] exp_v;
        int lat;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom); a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            exp_v = ref_op(o, a, b, c);
            do_op(o, a, b, c, 1'b1, lat);
            checks++;
            if (lat != 2 * NIB || {result, co, vo, no, zo} !== exp_v) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h ci=%b got %h lat %0d want %h lat %0d",
                         i, o, a, b, c, {result, co, vo, no, zo}, lat, exp_v, 2 * NIB);
            end
            start = 1'b0;
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int d0, lat;
        logic [W+3:0] exp_v;
        exp_v = ref_op(2'b01, 16'h4321, 16'h1111, 1'b1);
        d0 = done_cnt;
        op = 2'b01; a_in = 16'h4321; b_in = 16'h1111; ci = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        op = 2'b11; a_in = 16'hAAAA; b_in = 16'h5555; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int n = 4; n <= 40; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != 2 * NIB || {result, co, vo, no, zo} !== exp_v) begin
            errors++;
            $display("FAIL ignore_start got %h lat %0d want %h lat %0d", {result, co, vo, no, zo}, lat, exp_v, 2 * NIB);
        end
        repeat (12) tick();
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_done_count got %0d busy=%b want 1 busy=0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_back_to_back();
        int d0, lat1, lat2;
        logic [W+3:0] e1, e2, r1;
        e1 = ref_op(2'b11, 16'h1000, 16'h0001, 1'b1);
        e2 = ref_op(2'b01, 16'h7FFF, 16'h0001, 1'b0);
        d0 = done_cnt;
        do_op(2'b11, 16'h1000, 16'h0001, 1'b1, 1'b0, lat1);
        r1 = {result, co, vo, no, zo};
        do_op(2'b01, 16'h7FFF, 16'h0001, 1'b0, 1'b0, lat2);
        checks++;
        if (lat1 != 2 * NIB || r1 !== e1) begin
            errors++;
            $display("FAIL b2b_first got %h lat %0d want %h lat %0d", r1, lat1, e1, 2 * NIB);
        end
        checks++;
        if (lat2 != 2 * NIB || {result, co, vo, no, zo} !== e2) begin
            errors++;
            $display("FAIL b2b_second got %h lat %0d want %h lat %0d", {result, co, vo, no, zo}, lat2, e2, 2 * NIB);
        end
        repeat (4) tick();
        checks++;
        if (done_cnt - d0 != 2) begin
            errors++;
            $display("FAIL b2b_done_count got %0d want 2", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        op = 2'b01; a_in = 16'h1234; b_in = 16'h0FFF; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        d0 = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, co, vo, no, zo, alb_r, alb_s, alb_ci, alb_i} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %h want 0", {busy, done, result, co, vo, no, zo, alb_r, alb_s, alb_ci, alb_i});
        end
        tick();
        reset_n = 1'b1;
        repeat (12) tick();
        checks++;
        if (done_cnt != d0 || busy !== 1'b0 || result !== '0) begin
            errors++;
            $display("FAIL reset_mid_no_done dones=%0d busy=%b result=%h want 0 0 0", done_cnt - d0, busy, result);
        end
    endtask

`ifdef ALB_SEQ_ABORT_EN
    task automatic test_abort();
        int d0, lat;
        logic [W+3:0] keep;
        do_op(2'b01, 16'h0102, 16'h0304, 1'b0, 1'b0, lat);
        keep = ref_op(2'b01, 16'h0102, 16'h0304, 1'b0);
        tick();
        for (int w = 5; w <= 7; w += 2) begin
            d0 = done_cnt;
            op = 2'b11; a_in = 16'hFFFF; b_in = 16'h0001; ci = 1'b1; start = 1'b1;
            tick();
            start = 1'b0;
            repeat (w - 1) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL abort_busy[%0d] busy=%b done=%b want 0 0", w, busy, done);
            end
            repeat (12) tick();
            checks++;
            if (done_cnt != d0 || {result, co, vo, no, zo} !== keep) begin
                errors++;
                $display("FAIL abort_keep[%0d] dones=%0d got %h want 0 %h", w, done_cnt - d0, {result, co, vo, no, zo}, keep);
            end
        end
        abort = 1'b1;
        op = 2'b00; a_in = 16'h0F00; b_in = 16'h00F0; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle_start busy=%b want 1", busy);
        end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != 2 * NIB || result !== 16'h0FF0) begin
            errors++;
            $display("FAIL abort_idle_result got %h lat %0d want 0ff0 lat %0d", result, lat, 2 * NIB);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`ifdef ALB_SEQ_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alb_seq.md
# alb_seq

Multi-precision operation sequencer for the 4-bit arithmetic-logic block (ALB). It accepts a WIDTH-bit operation request from the datapath controller and issues it to the ALB one nibble at a time, least significant first, chaining carry between nibbles. It collects the result nibbles and returns the full-width result and flags with a start/busy/done handshake. It sits between the controller and the ALB, driving the ALB's operand/control inputs and consuming its result/flag outputs.

## Interface
- NIB, default 4: number of nibbles; WIDTH = 4*NIB; NIB ≥ 1
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when busy=0
- op  in  2  ALB operation: 00 OR, 01 ADD, 10 (~A)&B, 11 SUB (A−B−1+ci)
- a_in, b_in  in  WIDTH  operands, sampled at accept
- ci  in  1  carry-in for nibble 0, sampled at accept
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  last completed result
- co, vo, no, zo  out  1  last completed carry, overflow, negative, zero
- alb_r, alb_s  out  4  ALB operand nibbles
- alb_ci  out  1  ALB carry-in
- alb_i  out  2  ALB operation select
- alb_f  in  4  ALB result nibble
- alb_co, alb_vo  in  1  ALB carry and overflow

## Operation
- States: IDLE, ISSUE, CAPTURE.
- IDLE, start=1: latch a_in, b_in, op, and ci into the carry register; set nibble index k=0; go to ISSUE.
- ISSUE: alb_r=A[4k+3:4k], alb_s=B[4k+3:4k], alb_ci=carry register, alb_i=op. These are combinational from internal registers. The ALB registers them on this edge. Go to CAPTURE.
- CAPTURE: alb_f and alb_co are valid. On the edge:
  - store alb_f into buffer nibble k;
  - carry register ← alb_co;
  - if k<NIB−1: k←k+1, go to ISSUE;
  - else: go to IDLE and update the outputs as follows:
    - result ← full buffer including this nibble;
    - co ← alb_co;
    - vo ← alb_vo;
    - no ← result MSB;
    - zo ← (full result == 0);
    - done ← 1.
- Carry chain: ALB CO is already "no borrow" for SUB, so SUB with ci=1 gives A−B exactly. Logic ops: ALB returns CO=VO=0, so co=vo=0.
- In IDLE, alb_r, alb_s, alb_ci and alb_i are all 0.
- busy=1 in ISSUE and CAPTURE only.
- result and flags hold between operations. They change only at completion.

## Timing
- Reset: state IDLE; busy, done, result, co, vo, no, zo, alb_* all 0. The buffer and carry register are cleared.
- Latency: start accepted at edge E. busy rises after E. done=1 and busy=0 during the cycle following edge E+2·NIB (8 cycles for NIB=4). Result and flags are valid in that same cycle.
- Throughput: 2 cycles per nibble. A start asserted during the done cycle is accepted, so back-to-back operations are possible.
- start while busy=1 is ignored. Operand changes while busy have no effect.
- done is high for exactly one cycle per completed operation.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No done pulse.

## Configuration
- ALB_SEQ_ABORT_EN defined:
  - adds input port abort (1 bit);
  - abort=1 while busy forces IDLE on the next edge, with no done pulse;
  - result and flags keep their previous values;
  - abort has priority over the CAPTURE completion in the same cycle;
  - abort while idle has no effect, and start is still accepted.
- ALB_SEQ_ABORT_EN undefined: no abort port; every accepted operation runs to completion.

## Test plan
- ADD, a=0x1234, b=0x0FFF, ci=0 -> result=0x2233, co=0, vo=0, no=0, zo=0; done exactly 8 cycles after the start edge.
- ADD, a=0xFFFF, b=0x0001, ci=0 -> result=0x0000, co=1, zo=1, vo=0.
- SUB, a=0x8000, b=0x0001, ci=1 -> result=0x7FFF, co=1, vo=1, no=0. Then SUB, a=0x0001, b=0x0002, ci=1 -> 0xFFFF, co=0, no=1, vo=0.
- OR, a=0x0F0F, b=0xF000 -> 0xFF0F, co=0. Then op=10, a=0x00FF, b=0x0F0F -> 0x0F00, vo=0.
- Handshake: start pulsed again at cycle 3 of busy -> ignored, one done only. Start held during the done cycle -> second operation accepted, done again 8 cycles later.
- Reset at cycle 4 of an ADD -> outputs all 0 immediately, no done.
- With ALB_SEQ_ABORT_EN: abort at cycle 5 -> busy drops, no done, previous result retained.
